// File: rtl/dec_unbinder_if.sv
// dec_unbinder_if -- bundle between a decode requester and dec_unbinder.
//
// Signals:
//   start_decoding  request pulse (requester -> unbinder)
//   bound_hv        bound (rotated) hypervector, sampled with the start
//   level_hv        level item memory, NUM_LEVELS x HV_DIM, held while busy
//   busy            unbinder is scanning or presenting a result
//   done            one-cycle pulse, result outputs valid
//   decoded_level   index of the best-matching level
//   best_overlap    popcount overlap of that level
//
// Modports: master = requester, slave = dec_unbinder.
interface dec_unbinder_if #(
    parameter int HV_DIM     = 1024,
    parameter int NUM_LEVELS = 10,
    parameter int CNT_W      = $clog2(HV_DIM + 1)
);
    localparam int IDX_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;

    logic                  start_decoding;
    logic [HV_DIM-1:0]     bound_hv;
    logic [HV_DIM-1:0]     level_hv [0:NUM_LEVELS-1];
    logic                  busy;
    logic                  done;
    logic [IDX_W-1:0]      decoded_level;
    logic [CNT_W-1:0]      best_overlap;

    modport master (
        output start_decoding, bound_hv, level_hv,
        input  busy, done, decoded_level, best_overlap
    );

    modport slave (
        input  start_decoding, bound_hv, level_hv,
        output busy, done, decoded_level, best_overlap
    );
endinterface

// File: rtl/dec_unbinder.sv
// dec_unbinder -- undoes a channel's binding rotation on a hypervector and
// finds the level hypervector with the largest bitwise overlap, scanning one
// level per clock.
//
// Ports:
//   clk   single clock, rising edge
//   nrst  synchronous active-low reset
//   bus   dec_unbinder_if.slave: start_decoding/bound_hv/level_hv in,
//         busy/done/decoded_level/best_overlap out
//
// Timing: start accepted at edge t -> SCAN cycles t+1..t+NUM_LEVELS,
// done high in cycle t+NUM_LEVELS+1. Results are registered so they are
// already valid during the done cycle and hold until the next done.
module dec_unbinder #(
    parameter int HV_DIM     = 1024,
    parameter int NUM_LEVELS = 10,
    parameter int SHIFT      = 0,
    parameter int CNT_W      = $clog2(HV_DIM + 1)
) (
    input  logic           clk,
    input  logic           nrst,
    dec_unbinder_if.slave  bus
);
    localparam int IDX_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam int SH    = SHIFT % HV_DIM;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEVELS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [HV_DIM-1:0] unbound_reg, unbound_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [CNT_W-1:0]  best_cnt_reg, best_cnt_next;
    logic [IDX_W-1:0]  best_idx_reg, best_idx_next;
    logic [IDX_W-1:0]  decoded_reg, decoded_next;
    logic [CNT_W-1:0]  best_ovl_reg, best_ovl_next;

    logic [HV_DIM-1:0] rotated;
    logic [HV_DIM-1:0] hit;
    logic [CNT_W-1:0]  ovl;

    // Right rotation by SHIFT: pure wiring, undoes the encoder's left rotation.
    genvar gi;
    generate
        for (gi = 0; gi < HV_DIM; gi++) begin : g_rot
            assign rotated[gi] = bus.bound_hv[(gi + SH) % HV_DIM];
        end
    endgenerate

    // Full-width popcount of the overlap with the level under the scan index.
    // idx_reg never leaves 0..NUM_LEVELS-1, so the memory read is always in range.
    assign hit = unbound_reg & bus.level_hv[idx_reg];

    always_comb begin
        ovl = '0;
        for (int i = 0; i < HV_DIM; i++) begin
            ovl = ovl + {{(CNT_W-1){1'b0}}, hit[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg    <= IDLE;
            unbound_reg  <= '0;
            idx_reg      <= '0;
            best_cnt_reg <= '0;
            best_idx_reg <= '0;
            decoded_reg  <= '0;
            best_ovl_reg <= '0;
        end else begin
            state_reg    <= state_next;
            unbound_reg  <= unbound_next;
            idx_reg      <= idx_next;
            best_cnt_reg <= best_cnt_next;
            best_idx_reg <= best_idx_next;
            decoded_reg  <= decoded_next;
            best_ovl_reg <= best_ovl_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        unbound_next  = unbound_reg;
        idx_next      = idx_reg;
        best_cnt_next = best_cnt_reg;
        best_idx_next = best_idx_reg;
        decoded_next  = decoded_reg;
        best_ovl_next = best_ovl_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start_decoding) begin
                    unbound_next  = rotated;
                    idx_next      = '0;
                    best_cnt_next = '0;
                    best_idx_next = '0;
                    state_next    = SCAN;
                end
            end
            SCAN: begin
                // Strict compare keeps the lower index on ties.
                if (ovl > best_cnt_reg) begin
                    best_cnt_next = ovl;
                    best_idx_next = idx_reg;
                end
                if (idx_reg == LAST_IDX) begin
                    idx_next   = '0;
                    state_next = DONE;
                    // Publish on the edge into DONE so outputs are valid with done.
                    decoded_next  = best_idx_next;
                    best_ovl_next = best_cnt_next;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy          = (state_reg != IDLE);
    assign bus.done          = (state_reg == DONE);
    assign bus.decoded_level = decoded_reg;
    assign bus.best_overlap  = best_ovl_reg;
endmodule
